// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: single-outstanding imem request, Fetch->Decode register,
// redirect squash and stall hold with a one-entry return buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrc,
    input  logic [31:0] PCNext,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        ValidD
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcd_q, pcd_d;
    logic         valid_q, valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= F_REQ;
            pcf_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;

        case (state_q)
            F_REQ: begin
                if (imem_ready) state_d = F_WAIT;
            end
            F_WAIT: begin
                if (imem_rvalid) begin
                    if (!StallF) begin
                        instr_d = imem_rdata;
                        pcd_d   = pcf_q;
                        valid_d = 1'b1;
                        pcf_d   = pcf_q + PC_STEP;
                        state_d = F_REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = F_HOLD;
                    end
                end
            end
            F_HOLD: begin
                if (!StallF) begin
                    instr_d = buf_q;
                    pcd_d   = pcf_q;
                    valid_d = 1'b1;
                    pcf_d   = pcf_q + PC_STEP;
                    state_d = F_REQ;
                end
            end
            F_DROP: begin
                if (imem_rvalid) state_d = F_REQ;
            end
            default: state_d = F_REQ;
        endcase

        // Redirect overrides everything above; D keeps its contents but is invalidated.
        if (PCSrc) begin
            pcf_d   = PCNext;
            valid_d = 1'b0;
            instr_d = instr_q;
            pcd_d   = pcd_q;
            buf_d   = '0;
            if ((state_q == F_WAIT && !imem_rvalid) ||
                (state_q == F_REQ  && imem_ready)   ||
                (state_q == F_DROP && !imem_rvalid))
                state_d = F_DROP;
            else
                state_d = F_REQ;
        end
    end

    assign imem_req  = (state_q == F_REQ);
    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance covers PC wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, PCSrc, imem_ready, imem_rvalid;
    logic [31:0] PCNext, imem_rdata;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, pcf_a, instr_a, pcd_a;
    logic [31:0] addr_b, pcf_b, instr_b, pcd_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut_a (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrc(PCSrc), .PCNext(PCNext),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCF(pcf_a), .InstrD(instr_a), .PCD(pcd_a), .ValidD(valid_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_b (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrc(PCSrc), .PCNext(PCNext),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCF(pcf_b), .InstrD(instr_b), .PCD(pcd_b), .ValidD(valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        StallF = 0; PCSrc = 0; PCNext = '0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    endtask

    task automatic fetch(input logic [31:0] data);
        imem_ready = 1; step();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = data; step();
        imem_rvalid = 0;
    endtask

    initial begin
        idle();
        reset = 0;
        #12;
        // Reset state
        chk("rst_req", {31'b0, req_a}, 32'd1);
        chk("rst_addr", addr_a, 32'h0);
        chk("rst_valid", {31'b0, valid_a}, 32'd0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_pcd", pcd_a, 32'h0);
        chk("rst_pcf_b", pcf_b, 32'hFFFF_FFFC);
        reset = 1;
        step();

        // Basic fetch
        imem_ready = 1; step();
        chk("wait_req", {31'b0, req_a}, 32'd0);
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hE3A0_0001; step();
        imem_rvalid = 0;
        chk("basic_instr", instr_a, 32'hE3A0_0001);
        chk("basic_pcd", pcd_a, 32'h0);
        chk("basic_valid", {31'b0, valid_a}, 32'd1);
        chk("basic_addr", addr_a, 32'h4);
        chk("basic_req", {31'b0, req_a}, 32'd1);
        chk("wrap_pcd", pcd_b, 32'hFFFF_FFFC);
        chk("wrap_addr", addr_b, 32'h0);

        fetch(32'h1111_1111);
        chk("f4_pcd", pcd_a, 32'h4);

        // Stall hold on the response for 0x8
        imem_ready = 1; step();
        imem_ready = 0; StallF = 1; imem_rvalid = 1; imem_rdata = 32'hE081_1002; step();
        imem_rvalid = 0; imem_rdata = '0;
        chk("hold_req", {31'b0, req_a}, 32'd0);
        chk("hold_instr", instr_a, 32'h1111_1111);
        chk("hold_pcd", pcd_a, 32'h4);
        step();
        chk("hold2_req", {31'b0, req_a}, 32'd0);
        chk("hold2_instr", instr_a, 32'h1111_1111);
        StallF = 0; step();
        chk("rel_instr", instr_a, 32'hE081_1002);
        chk("rel_pcd", pcd_a, 32'h8);
        chk("rel_valid", {31'b0, valid_a}, 32'd1);
        chk("rel_req", {31'b0, req_a}, 32'd1);
        chk("rel_addr", addr_a, 32'hC);

        fetch(32'h2222_2222);
        chk("fC_addr", addr_a, 32'h10);

        // Redirect while waiting on 0x10
        imem_ready = 1; step();
        imem_ready = 0; PCSrc = 1; PCNext = 32'h40; step();
        PCSrc = 0; PCNext = '0;
        chk("rdw_valid", {31'b0, valid_a}, 32'd0);
        chk("rdw_req", {31'b0, req_a}, 32'd0);
        chk("rdw_addr", addr_a, 32'h40);
        chk("rdw_instr", instr_a, 32'h2222_2222);
        step();
        chk("drop_req", {31'b0, req_a}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
        imem_rvalid = 0;
        chk("drop_done_req", {31'b0, req_a}, 32'd1);
        chk("drop_done_addr", addr_a, 32'h40);
        chk("drop_instr", instr_a, 32'h2222_2222);
        chk("drop_valid", {31'b0, valid_a}, 32'd0);

        // Redirect coinciding with rvalid
        imem_ready = 1; step();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        PCSrc = 1; PCNext = 32'h40; step();
        imem_rvalid = 0; PCSrc = 0;
        chk("rdv_req", {31'b0, req_a}, 32'd1);
        chk("rdv_addr", addr_a, 32'h40);
        chk("rdv_valid", {31'b0, valid_a}, 32'd0);
        chk("rdv_instr", instr_a, 32'h2222_2222);

        fetch(32'h3333_3333);
        chk("f40_pcd", pcd_a, 32'h40);
        chk("f40_addr", addr_a, 32'h44);

        // Redirect in F_REQ while the request is accepted -> drop pending
        imem_ready = 1; PCSrc = 1; PCNext = 32'h80; step();
        imem_ready = 0; PCSrc = 0;
        chk("rdr_req", {31'b0, req_a}, 32'd0);
        chk("rdr_addr", addr_a, 32'h80);
        imem_rvalid = 1; step();
        imem_rvalid = 0;
        chk("rdr_done_req", {31'b0, req_a}, 32'd1);
        chk("rdr_done_valid", {31'b0, valid_a}, 32'd0);

        // Async reset while waiting
        imem_ready = 1; step();
        imem_ready = 0;
        chk("pre_rst_req", {31'b0, req_a}, 32'd0);
        #2 reset = 0;
        #1;
        chk("arst_req", {31'b0, req_a}, 32'd1);
        chk("arst_addr", addr_a, 32'h0);
        chk("arst_instr", instr_a, 32'h0);
        chk("arst_pcd", pcd_a, 32'h0);
        #3 reset = 1;
        imem_rvalid = 1; imem_rdata = 32'h5555_5555; step();
        imem_rvalid = 0;
        chk("stale_req", {31'b0, req_a}, 32'd1);
        chk("stale_addr", addr_a, 32'h0);
        chk("stale_valid", {31'b0, valid_a}, 32'd0);
        chk("stale_instr", instr_a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
